// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared state/requester types and default widths for the cacheline arbiter
package cache_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} req_id_t;
endpackage

// File: rtl/cacheline_arbiter_if.sv
// cacheline_arbiter_if: icache, dcache and adaptor signals around the arbiter
interface cacheline_arbiter_if #(
  parameter int ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int LINE_W = cache_arb_pkg::LINE_W,
  parameter int BE_W   = LINE_W / 8
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_byte_enable;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_byte_enable;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, d_byte_enable, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, d_byte_enable, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/cache_arb_pick.sv
// cache_arb_pick: winner select between icache and dcache requests
// CACHE_ARB_RR_EN picks the cache not served last on contention, else dcache always wins
module cache_arb_pick
  import cache_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
`ifdef CACHE_ARB_RR_EN
  input  req_id_t last,
`endif
  output logic    any,
  output req_id_t win
);
  always_comb begin
    any = i_req || d_req;
`ifdef CACHE_ARB_RR_EN
    win = (d_req && (!i_req || last == REQ_I)) ? REQ_D : REQ_I;
`else
    win = d_req ? REQ_D : REQ_I;
`endif
  end
endmodule

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares the cacheline adaptor between icache and dcache, one line at a time
// CACHE_ARB_RR_EN selects round-robin arbitration instead of fixed dcache priority
module cacheline_arbiter #(
  parameter int ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int LINE_W = cache_arb_pkg::LINE_W,
  parameter int BE_W   = LINE_W / 8
) (
  input logic                clk,
  input logic                rst,
  cacheline_arbiter_if.slave bus
);
  import cache_arb_pkg::*;
  arb_state_t state, state_n;
  req_id_t grant, win;
  logic any, d_req, op_wr, take;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q, i_rdata_q, d_rdata_q;
  logic [BE_W-1:0] be_q;
`ifdef CACHE_ARB_RR_EN
  req_id_t last;
`endif
  assign d_req = bus.d_read || bus.d_write;
  cache_arb_pick u_pick (
    .i_req (bus.i_read),
    .d_req (d_req),
`ifdef CACHE_ARB_RR_EN
    .last  (last),
`endif
    .any   (any),
    .win   (win)
  );
  always_comb begin
    state_n = state == IDLE ? (any ? BUSY : IDLE) : state == BUSY ? (bus.mem_resp ? RESP : BUSY) : IDLE;
    take = state == BUSY && bus.mem_resp;
    bus.mem_read = state == BUSY && !op_wr;
    bus.mem_write = state == BUSY && op_wr;
    bus.mem_address = addr_q;
    bus.mem_wdata = wdata_q;
    bus.mem_byte_enable = be_q;
    bus.i_resp = state == RESP && grant == REQ_I;
    bus.d_resp = state == RESP && grant == REQ_D;
    bus.i_rdata = i_rdata_q;
    bus.d_rdata = d_rdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= REQ_I;
      op_wr <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef CACHE_ARB_RR_EN
      last <= REQ_I;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && any) begin
        grant <= win;
        op_wr <= win == REQ_D && bus.d_write;
        addr_q <= win == REQ_D ? bus.d_address : bus.i_address;
        wdata_q <= win == REQ_D ? bus.d_wdata : '0;
        be_q <= win == REQ_D ? bus.d_byte_enable : '1;
      end
      if (take && !op_wr && grant == REQ_I) i_rdata_q <= bus.mem_rdata;
      if (take && !op_wr && grant == REQ_D) d_rdata_q <= bus.mem_rdata;
`ifdef CACHE_ARB_RR_EN
      if (take) last <= grant;
`endif
    end
  end
  a_no_rd_wr: assert property (@(posedge clk) disable iff (rst) !(bus.d_read && bus.d_write));
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: randomized transactions against a per-cache pending-request model
module tb_cacheline_arbiter;
  import cache_arb_pkg::*;
  localparam int AW = ADDR_W;
  localparam int LW = LINE_W;
  localparam int BW = LINE_W / 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cacheline_arbiter_if bus ();
  cacheline_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic i_pend, d_pend, d_wr, last_d;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wd, exp_i_rd, exp_d_rd;
  logic [BW-1:0] d_be;
  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32+:32] = $urandom;
    return v;
  endfunction
  task automatic drive();
    bus.i_read = i_pend;
    bus.i_address = i_addr;
    bus.d_read = d_pend && !d_wr;
    bus.d_write = d_pend && d_wr;
    bus.d_address = d_addr;
    bus.d_wdata = d_wd;
    bus.d_byte_enable = d_be;
  endtask
  task automatic new_i();
    i_pend = 1'b1;
    i_addr = AW'($urandom);
  endtask
  task automatic new_d();
    d_pend = 1'b1;
    d_wr = 1'($urandom_range(0, 1));
    d_addr = AW'($urandom);
    d_wd = rand_line();
    d_be = BW'($urandom);
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_read"}, bus.mem_read, 0);
    check({tag, "_mem_write"}, bus.mem_write, 0);
    check({tag, "_i_resp"}, bus.i_resp, 0);
    check({tag, "_d_resp"}, bus.d_resp, 0);
  endtask
  task automatic serve(input int lat, input logic [LW-1:0] rd, input logic stray);
    logic win_d;
    int waited;
`ifdef CACHE_ARB_RR_EN
    win_d = d_pend && (!i_pend || !last_d);
`else
    win_d = d_pend;
`endif
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(bus.mem_read || bus.mem_write) && waited < 4);
    check("op_latency", waited, 1);
    check("mem_read", bus.mem_read, !(win_d && d_wr));
    check("mem_write", bus.mem_write, win_d && d_wr);
    check("mem_address", bus.mem_address, win_d ? d_addr : i_addr);
    check("mem_byte_enable", bus.mem_byte_enable, win_d ? d_be : {BW{1'b1}});
    if (win_d && d_wr) check("mem_wdata", bus.mem_wdata, d_wd);
    for (int k = 0; k < lat; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        if (!i_pend) new_i();
        else if (!d_pend) new_d();
        drive();
      end
      @(negedge clk);
      check("busy_hold", bus.mem_read || bus.mem_write, 1);
      check("busy_no_resp", bus.i_resp || bus.d_resp, 0);
    end
    bus.mem_resp = 1'b1;
    bus.mem_rdata = rd;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    bus.mem_rdata = rand_line();
    check("i_resp", bus.i_resp, !win_d);
    check("d_resp", bus.d_resp, win_d);
    check("op_dropped", bus.mem_read || bus.mem_write, 0);
    if (!win_d) exp_i_rd = rd;
    else if (!d_wr) exp_d_rd = rd;
    check("i_rdata", bus.i_rdata, exp_i_rd);
    check("d_rdata", bus.d_rdata, exp_d_rd);
    last_d = win_d;
    if (win_d) d_pend = 1'b0;
    else i_pend = 1'b0;
    drive();
    if (stray) bus.mem_resp = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    check("resp_one_cycle", bus.i_resp || bus.d_resp, 0);
    check("i_rdata_hold", bus.i_rdata, exp_i_rd);
    check("d_rdata_hold", bus.d_rdata, exp_d_rd);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1);
  end
  initial begin
    i_pend = 0; d_pend = 0; d_wr = 0; last_d = 0;
    i_addr = '0; d_addr = '0; d_wd = '0; d_be = '0;
    exp_i_rd = '0; exp_d_rd = '0;
    drive();
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_mem_address", bus.mem_address, 0);
    check("reset_mem_wdata", bus.mem_wdata, 0);
    check("reset_mem_be", bus.mem_byte_enable, 0);
    check("reset_i_rdata", bus.i_rdata, 0);
    check("reset_d_rdata", bus.d_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    i_pend = 1'b1;
    i_addr = 32'h0000_1000;
    drive();
    serve(7, {32{8'hA5}}, 1'b0);
    d_pend = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_2000;
    d_wd = {8{32'h1234_5678}}; d_be = {BW{1'b1}};
    drive();
    serve(3, rand_line(), 1'b0);
    i_pend = 1'b1; i_addr = AW'($urandom);
    d_pend = 1'b1; d_wr = 1'b0; d_addr = AW'($urandom); d_be = BW'($urandom);
    drive();
    serve(2, rand_line(), 1'b0);
    serve(2, rand_line(), 1'b0);
    for (int r = 0; r < 4; r++) begin
      if (!i_pend) new_i();
      if (!d_pend) begin new_d(); d_wr = 1'b0; end
      drive();
      serve(1, rand_line(), 1'b0);
    end
    for (int r = 0; r < 60; r++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) new_i();
      if (!d_pend && $urandom_range(0, 1) == 1) new_d();
      if (!i_pend && !d_pend) new_i();
      drive();
      serve($urandom_range(0, 6), rand_line(), 1'($urandom_range(0, 1)));
    end
    while (i_pend || d_pend) serve($urandom_range(0, 3), rand_line(), 1'b0);
    new_i();
    drive();
    @(negedge clk);
    check("rst_pre_read", bus.mem_read, 1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_mem_address", bus.mem_address, 0);
    check("async_rst_i_rdata", bus.i_rdata, 0);
    check("async_rst_d_rdata", bus.d_rdata, 0);
    exp_i_rd = '0; exp_d_rd = '0; last_d = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
    drive();
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp = 1'b1;
    bus.mem_rdata = rand_line();
    @(negedge clk);
    bus.mem_resp = 1'b0;
    check_idle_outputs("late_resp");
    @(negedge clk);
    check_idle_outputs("late_resp2");
    new_d();
    d_wr = 1'b0;
    drive();
    serve(3, rand_line(), 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
